// File: rtl/upc_loop_monitor_pkg.sv
// Shared types and constants for the loop-monitor slice.
package upc_loop_monitor_pkg;

    // Default width of every statistics counter.
    localparam int unsigned CNT_W_DEFAULT = 32;

    // Monitor FSM encoding is visible on the mon_state output, so it is pinned explicitly.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_CONT = 2'd2,
        FINISHED  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/upc_loop_monitor_sat_counter.sv
// Saturating up/down counter with synchronous clear.
// Clear wins over inc/dec; simultaneous inc and dec hold the value;
// the count never wraps past all-ones or below zero.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment or floor-clamped decrement.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q != '1) count_d = count_q + W'(1);
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/upc_loop_monitor.sv
// Observes an HLS-style pipelined loop (ap_ctrl handshake plus pipeline
// stage qualifiers) and gathers invocation/iteration/latency statistics.
// Optional feature: define UPC_LOOP_MONITOR_STALL_EN to build the
// start-stage stall counter; otherwise stall_cycles reads 0.
module upc_loop_monitor
    import upc_loop_monitor_pkg::*;
#(
    parameter int unsigned STATE_W = 2,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    input  logic               finish,
    output logic [1:0]         mon_state,
    output logic [CNT_W-1:0]   invocations,
    output logic [CNT_W-1:0]   iterations,
    output logic [CNT_W-1:0]   cycles,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   last_latency,
    output logic [CNT_W-1:0]   last_trip,
    output logic [CNT_W-1:0]   in_flight,
    output logic               done_pulse
);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] last_latency_q, last_latency_d;
    logic [CNT_W-1:0] last_trip_q, last_trip_d;
    logic             done_pulse_q, done_pulse_d;
    logic [CNT_W-1:0] lat_acc, trip_acc;

    logic start_ev, end_ev, quit_ev;
    logic live, run, enter, done_ev, restart;
    logic start_cnt, end_cnt, quit_clr, new_inv, acc_clr;

    // Pipeline events and the qualified counter controls. finish freezes
    // every counter on its own edge, not only once FINISHED is reached.
    always_comb begin
        start_ev  = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
        end_ev    = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
        quit_ev   = (cur_state == quit_state) && quit_enable && !quit_block;
        live      = !finish && (state_q != FINISHED);
        run       = live && (state_q == RUN);
        enter     = live && (state_q == IDLE) && loop_start;
        done_ev   = run && loop_done;
        restart   = done_ev && loop_start && loop_ready;
        start_cnt = run && start_ev && !(quit_ev && !quit_at_end);
        end_cnt   = run && end_ev;
        quit_clr  = run && quit_ev;
        new_inv   = enter || restart;
        acc_clr   = enter || done_ev;
    end

    // Monitor FSM next state; finish overrides everything.
    always_comb begin
        state_d = state_q;
        if (finish) begin
            state_d = FINISHED;
        end else begin
            case (state_q)
                IDLE:      if (loop_start) state_d = RUN;
                RUN: begin
                    if (loop_done) begin
                        if (loop_start && loop_ready) state_d = RUN;
                        else if (loop_continue)       state_d = IDLE;
                        else                          state_d = WAIT_CONT;
                    end
                end
                WAIT_CONT: if (loop_continue) state_d = IDLE;
                FINISHED:  state_d = FINISHED;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Completion capture: latency and trip both include the done cycle itself.
    always_comb begin
        last_latency_d = last_latency_q;
        last_trip_d    = last_trip_q;
        done_pulse_d   = done_ev;
        if (done_ev) begin
            last_latency_d = (lat_acc == '1) ? lat_acc : lat_acc + CNT_W'(1);
            last_trip_d    = (end_cnt && trip_acc != '1) ? trip_acc + CNT_W'(1) : trip_acc;
        end
    end

    // State and completion registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            last_latency_q <= '0;
            last_trip_q    <= '0;
            done_pulse_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_latency_q <= last_latency_d;
            last_trip_q    <= last_trip_d;
            done_pulse_q   <= done_pulse_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_invocations (
        .clock(clock), .reset(reset), .inc(new_inv), .dec(1'b0), .clr(1'b0), .count(invocations)
    );
    sat_counter #(.W(CNT_W)) u_iterations (
        .clock(clock), .reset(reset), .inc(end_cnt), .dec(1'b0), .clr(1'b0), .count(iterations)
    );
    sat_counter #(.W(CNT_W)) u_cycles (
        .clock(clock), .reset(reset), .inc(run), .dec(1'b0), .clr(1'b0), .count(cycles)
    );
    sat_counter #(.W(CNT_W)) u_in_flight (
        .clock(clock), .reset(reset), .inc(start_cnt), .dec(end_cnt), .clr(quit_clr), .count(in_flight)
    );
    sat_counter #(.W(CNT_W)) u_lat_acc (
        .clock(clock), .reset(reset), .inc(run), .dec(1'b0), .clr(acc_clr), .count(lat_acc)
    );
    sat_counter #(.W(CNT_W)) u_trip_acc (
        .clock(clock), .reset(reset), .inc(end_cnt), .dec(1'b0), .clr(acc_clr), .count(trip_acc)
    );

`ifdef UPC_LOOP_MONITOR_STALL_EN
    logic stall_inc;

    // A RUN cycle where the start stage is valid but held back.
    always_comb begin
        stall_inc = run && (cur_state == iter_start_state) && iter_start_enable && iter_start_block;
    end

    sat_counter #(.W(CNT_W)) u_stall (
        .clock(clock), .reset(reset), .inc(stall_inc), .dec(1'b0), .clr(1'b0), .count(stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

    assign mon_state    = state_q;
    assign last_latency = last_latency_q;
    assign last_trip    = last_trip_q;
    assign done_pulse   = done_pulse_q;

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Self-checking bench for upc_loop_monitor: a 32-bit instance against a
// cycle-level behavioural model, plus a 4-bit instance for saturation.
module tb_upc_loop_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic       iter_start_block, iter_end_block, quit_block;
    logic       iter_start_enable, iter_end_enable, quit_enable;
    logic       loop_start, loop_ready, loop_done, loop_continue;
    logic       quit_at_end, finish;

    logic [1:0]  d_state;
    logic [31:0] d_inv, d_iter, d_cyc, d_stall, d_lat, d_trip, d_infl;
    logic        d_done;
    logic [1:0]  s_state;
    logic [3:0]  s_inv, s_iter, s_cyc, s_stall, s_lat, s_trip, s_infl;
    logic        s_done;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state (unbounded integers; 32-bit saturation is never reached).
    int     m_mode;
    longint m_inv, m_iter, m_cyc, m_stall, m_lat_run, m_trip_run, m_last_lat, m_last_trip, m_infl;
    bit     m_done;

    always #5 clock = ~clock;

    upc_loop_monitor #(.STATE_W(2), .CNT_W(32)) u_dut (
        .clock(clock), .reset(reset), .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state), .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block), .quit_block(quit_block), .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable), .loop_start(loop_start),
        .loop_ready(loop_ready), .loop_done(loop_done), .loop_continue(loop_continue),
        .quit_at_end(quit_at_end), .finish(finish), .mon_state(d_state), .invocations(d_inv),
        .iterations(d_iter), .cycles(d_cyc), .stall_cycles(d_stall), .last_latency(d_lat),
        .last_trip(d_trip), .in_flight(d_infl), .done_pulse(d_done)
    );

    upc_loop_monitor #(.STATE_W(2), .CNT_W(4)) u_small (
        .clock(clock), .reset(reset), .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state), .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block), .quit_block(quit_block), .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable), .loop_start(loop_start),
        .loop_ready(loop_ready), .loop_done(loop_done), .loop_continue(loop_continue),
        .quit_at_end(quit_at_end), .finish(finish), .mon_state(s_state), .invocations(s_inv),
        .iterations(s_iter), .cycles(s_cyc), .stall_cycles(s_stall), .last_latency(s_lat),
        .last_trip(s_trip), .in_flight(s_infl), .done_pulse(s_done)
    );

    function automatic longint sat15(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic longint exp_stall(input longint v);
`ifdef UPC_LOOP_MONITOR_STALL_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Quiet inputs: every reference state matches cur_state, all stages idle.
    task automatic idle_inputs();
        cur_state = 2'd0; iter_start_state = 2'd0; iter_end_state = 2'd0; quit_state = 2'd0;
        iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
        iter_start_enable = 1'b0; iter_end_enable = 1'b0; quit_enable = 1'b0;
        loop_start = 1'b0; loop_ready = 1'b1; loop_done = 1'b0; loop_continue = 1'b1;
        quit_at_end = 1'b0; finish = 1'b0;
    endtask

    // Advance the model by one clock from the current inputs, then clock the DUT.
    task automatic tick();
        bit sev, eev, qev, stl;
        sev = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
        eev = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
        qev = (cur_state == quit_state) && quit_enable && !quit_block;
        stl = (cur_state == iter_start_state) && iter_start_enable && iter_start_block;
        m_done = 1'b0;
        if (reset) begin
            m_mode = 0; m_inv = 0; m_iter = 0; m_cyc = 0; m_stall = 0;
            m_lat_run = 0; m_trip_run = 0; m_last_lat = 0; m_last_trip = 0; m_infl = 0;
        end else if (finish || m_mode == 3) begin
            m_mode = 3;
        end else if (m_mode == 0) begin
            if (loop_start) begin
                m_inv++; m_lat_run = 0; m_trip_run = 0; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_cyc++; m_lat_run++;
            if (stl) m_stall++;
            if (eev) begin m_iter++; m_trip_run++; end
            if (qev) m_infl = 0;
            else begin
                m_infl = m_infl + sev - eev;
                if (m_infl < 0) m_infl = 0;
            end
            if (loop_done) begin
                m_last_lat = m_lat_run; m_last_trip = m_trip_run; m_done = 1'b1;
                if (loop_start && loop_ready) begin
                    m_inv++; m_lat_run = 0; m_trip_run = 0;
                end else if (loop_continue) m_mode = 0;
                else m_mode = 2;
            end
        end else begin
            if (loop_continue) m_mode = 0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        n_checks++; if (d_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d exp 0", d_state); end
        n_checks++; if (d_inv !== 32'd0 || d_iter !== 32'd0 || d_cyc !== 32'd0 || d_stall !== 32'd0) begin
            n_errors++; $display("FAIL reset_counters got inv=%0d iter=%0d cyc=%0d stall=%0d exp all 0", d_inv, d_iter, d_cyc, d_stall); end
        n_checks++; if (d_lat !== 32'd0 || d_trip !== 32'd0 || d_infl !== 32'd0 || d_done !== 1'b0) begin
            n_errors++; $display("FAIL reset_outputs got lat=%0d trip=%0d infl=%0d done=%0d exp all 0", d_lat, d_trip, d_infl, d_done); end
    endtask

    // One start, four start/end overlapping iterations, then done.
    task automatic test_basic();
        idle_inputs();
        do_reset();
        loop_start = 1'b1; tick(); loop_start = 1'b0;
        n_checks++; if (d_state !== 2'd1) begin n_errors++; $display("FAIL basic_enter_run got %0d exp 1", d_state); end
        for (int k = 0; k < 5; k++) begin
            iter_start_enable = (k < 4);
            iter_end_enable   = (k >= 1);
            tick();
        end
        iter_start_enable = 1'b0; iter_end_enable = 1'b0;
        loop_done = 1'b1; tick(); loop_done = 1'b0;
        n_checks++; if (d_inv !== 32'd1) begin n_errors++; $display("FAIL basic_invocations got %0d exp 1", d_inv); end
        n_checks++; if (d_iter !== 32'd4) begin n_errors++; $display("FAIL basic_iterations got %0d exp 4", d_iter); end
        n_checks++; if (d_trip !== 32'd4) begin n_errors++; $display("FAIL basic_last_trip got %0d exp 4", d_trip); end
        n_checks++; if (d_infl !== 32'd0) begin n_errors++; $display("FAIL basic_in_flight got %0d exp 0", d_infl); end
        n_checks++; if (d_lat !== 32'd6) begin n_errors++; $display("FAIL basic_last_latency got %0d exp 6", d_lat); end
        n_checks++; if (d_cyc !== 32'd6) begin n_errors++; $display("FAIL basic_cycles got %0d exp 6", d_cyc); end
        n_checks++; if (d_done !== 1'b1) begin n_errors++; $display("FAIL basic_done_pulse_hi got %0d exp 1", d_done); end
        tick();
        n_checks++; if (d_done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse_lo got %0d exp 0", d_done); end
        n_checks++; if (d_state !== 2'd0) begin n_errors++; $display("FAIL basic_back_idle got %0d exp 0", d_state); end
    endtask

    task automatic test_wait_cont();
        idle_inputs();
        do_reset();
        loop_start = 1'b1; tick(); loop_start = 1'b0;
        tick();
        loop_done = 1'b1; loop_continue = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            loop_done = 1'b0;
            n_checks++; if (d_state !== 2'd2) begin n_errors++; $display("FAIL wait_cont_state[%0d] got %0d exp 2", k, d_state); end
            n_checks++; if (d_done !== (k == 0)) begin n_errors++; $display("FAIL wait_cont_done[%0d] got %0d exp %0d", k, d_done, k == 0); end
        end
        loop_continue = 1'b1; tick();
        n_checks++; if (d_state !== 2'd0) begin n_errors++; $display("FAIL wait_cont_release got %0d exp 0", d_state); end
        n_checks++; if (d_lat !== 32'd2) begin n_errors++; $display("FAIL wait_cont_latency got %0d exp 2", d_lat); end
    endtask

    task automatic test_stall();
        idle_inputs();
        do_reset();
        loop_start = 1'b1; tick(); loop_start = 1'b0;
        iter_start_enable = 1'b1; iter_start_block = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        iter_start_enable = 1'b0; iter_start_block = 1'b0;
        tick();
        n_checks++; if (d_stall !== 32'(exp_stall(5))) begin n_errors++; $display("FAIL stall_count got %0d exp %0d", d_stall, exp_stall(5)); end
        n_checks++; if (d_infl !== 32'd0) begin n_errors++; $display("FAIL stall_in_flight got %0d exp 0", d_infl); end
        loop_done = 1'b1; tick(); loop_done = 1'b0;
    endtask

    task automatic test_saturation();
        idle_inputs();
        do_reset();
        loop_start = 1'b1; tick(); loop_start = 1'b0;
        iter_end_enable = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        iter_end_enable = 1'b0;
        n_checks++; if (s_iter !== 4'd15) begin n_errors++; $display("FAIL sat_iterations_w4 got %0d exp 15", s_iter); end
        n_checks++; if (s_cyc !== 4'd15) begin n_errors++; $display("FAIL sat_cycles_w4 got %0d exp 15", s_cyc); end
        n_checks++; if (d_iter !== 32'd20) begin n_errors++; $display("FAIL sat_iterations_w32 got %0d exp 20", d_iter); end
        n_checks++; if (s_infl !== 4'd0) begin n_errors++; $display("FAIL sat_in_flight_floor got %0d exp 0", s_infl); end
        loop_done = 1'b1; tick(); loop_done = 1'b0;
        n_checks++; if (s_lat !== 4'd15) begin n_errors++; $display("FAIL sat_latency_w4 got %0d exp 15", s_lat); end
        n_checks++; if (d_lat !== 32'd21) begin n_errors++; $display("FAIL sat_latency_w32 got %0d exp 21", d_lat); end
    endtask

    task automatic test_quit();
        idle_inputs();
        do_reset();
        loop_start = 1'b1; tick(); loop_start = 1'b0;
        iter_start_enable = 1'b1; tick(); tick();
        n_checks++; if (d_infl !== 32'd2) begin n_errors++; $display("FAIL quit_pre_in_flight got %0d exp 2", d_infl); end
        quit_enable = 1'b1; quit_at_end = 1'b0; tick();
        quit_enable = 1'b0; iter_start_enable = 1'b0;
        n_checks++; if (d_infl !== 32'd0) begin n_errors++; $display("FAIL quit_first_clear got %0d exp 0", d_infl); end
        tick();
        n_checks++; if (d_infl !== 32'd0) begin n_errors++; $display("FAIL quit_start_dropped got %0d exp 0", d_infl); end
        iter_end_enable = 1'b1; quit_enable = 1'b1; quit_at_end = 1'b1; tick();
        iter_end_enable = 1'b0; quit_enable = 1'b0;
        n_checks++; if (d_iter !== 32'd1) begin n_errors++; $display("FAIL quit_last_end_once got %0d exp 1", d_iter); end
        loop_done = 1'b1; tick(); loop_done = 1'b0;
        n_checks++; if (d_trip !== 32'd1) begin n_errors++; $display("FAIL quit_last_trip got %0d exp 1", d_trip); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        do_reset();
        loop_start = 1'b1; tick();
        iter_end_enable = 1'b1; tick(); tick();
        loop_done = 1'b1; loop_ready = 1'b1; tick();
        loop_done = 1'b0; loop_start = 1'b0; iter_end_enable = 1'b0;
        n_checks++; if (d_state !== 2'd1) begin n_errors++; $display("FAIL b2b_state got %0d exp 1", d_state); end
        n_checks++; if (d_inv !== 32'd2) begin n_errors++; $display("FAIL b2b_invocations got %0d exp 2", d_inv); end
        n_checks++; if (d_trip !== 32'd3 || d_lat !== 32'd3) begin
            n_errors++; $display("FAIL b2b_capture got trip=%0d lat=%0d exp trip=3 lat=3", d_trip, d_lat); end
        loop_done = 1'b1; tick(); loop_done = 1'b0;
        n_checks++; if (d_lat !== 32'd1 || d_trip !== 32'd0) begin
            n_errors++; $display("FAIL b2b_second got lat=%0d trip=%0d exp lat=1 trip=0", d_lat, d_trip); end
    endtask

    task automatic test_finish();
        longint snap_iter, snap_cyc, snap_infl;
        idle_inputs();
        do_reset();
        loop_start = 1'b1; tick(); loop_start = 1'b0;
        iter_end_enable = 1'b1; loop_done = 1'b1; tick(); loop_done = 1'b0;
        loop_start = 1'b1; tick(); loop_start = 1'b0;
        iter_start_enable = 1'b1; iter_end_enable = 1'b0; tick(); tick();
        finish = 1'b1; tick(); finish = 1'b0;
        snap_iter = m_iter; snap_cyc = m_cyc; snap_infl = m_infl;
        n_checks++; if (d_state !== 2'd3) begin n_errors++; $display("FAIL finish_state got %0d exp 3", d_state); end
        iter_end_enable = 1'b1; loop_start = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        iter_end_enable = 1'b0; loop_start = 1'b0;
        n_checks++; if (d_state !== 2'd3) begin n_errors++; $display("FAIL finish_held got %0d exp 3", d_state); end
        n_checks++; if (d_iter !== 32'(snap_iter) || d_cyc !== 32'(snap_cyc) || d_infl !== 32'(snap_infl) || d_inv !== 32'd2) begin
            n_errors++; $display("FAIL finish_frozen got iter=%0d cyc=%0d infl=%0d inv=%0d exp %0d %0d %0d 2",
                                 d_iter, d_cyc, d_infl, d_inv, snap_iter, snap_cyc, snap_infl); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++; if (d_state !== 2'd0) begin n_errors++; $display("FAIL finish_reset_state got %0d exp 0", d_state); end
        n_checks++; if (d_inv !== 32'd0 || d_iter !== 32'd0 || d_cyc !== 32'd0 || d_infl !== 32'd0 || d_lat !== 32'd0 || d_trip !== 32'd0) begin
            n_errors++; $display("FAIL finish_reset_counters got inv=%0d iter=%0d cyc=%0d infl=%0d lat=%0d trip=%0d exp all 0",
                                 d_inv, d_iter, d_cyc, d_infl, d_lat, d_trip); end
    endtask

    task automatic test_random();
        idle_inputs();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cur_state         = 2'($urandom_range(0, 3));
            iter_start_state  = 2'($urandom_range(0, 3));
            iter_end_state    = 2'($urandom_range(0, 3));
            quit_state        = 2'($urandom_range(0, 3));
            iter_start_block  = ($urandom_range(0, 3) == 0);
            iter_end_block    = ($urandom_range(0, 3) == 0);
            quit_block        = ($urandom_range(0, 1) == 0);
            iter_start_enable = ($urandom_range(0, 3) != 0);
            iter_end_enable   = ($urandom_range(0, 3) != 0);
            quit_enable       = ($urandom_range(0, 7) == 0);
            quit_at_end       = $urandom_range(0, 1) != 0;
            loop_start        = ($urandom_range(0, 3) == 0);
            loop_ready        = $urandom_range(0, 1) != 0;
            loop_done         = ($urandom_range(0, 9) == 0);
            loop_continue     = ($urandom_range(0, 2) != 0);
            finish            = ($urandom_range(0, 499) == 0);
            reset             = ($urandom_range(0, 399) == 0) || (m_mode == 3 && $urandom_range(0, 3) == 0);
            tick();
            n_checks++;
            if (d_state !== 2'(m_mode) || d_inv !== 32'(m_inv) || d_iter !== 32'(m_iter) || d_cyc !== 32'(m_cyc) ||
                d_stall !== 32'(exp_stall(m_stall)) || d_lat !== 32'(m_last_lat) || d_trip !== 32'(m_last_trip) ||
                d_infl !== 32'(m_infl) || d_done !== m_done) begin
                n_errors++;
                $display("FAIL random[%0d] got st=%0d inv=%0d it=%0d cy=%0d stl=%0d lat=%0d trip=%0d infl=%0d dn=%0d exp st=%0d inv=%0d it=%0d cy=%0d stl=%0d lat=%0d trip=%0d infl=%0d dn=%0d",
                         n, d_state, d_inv, d_iter, d_cyc, d_stall, d_lat, d_trip, d_infl, d_done,
                         m_mode, m_inv, m_iter, m_cyc, exp_stall(m_stall), m_last_lat, m_last_trip, m_infl, m_done);
            end
            n_checks++;
            if (s_inv !== 4'(sat15(m_inv)) || s_iter !== 4'(sat15(m_iter)) || s_cyc !== 4'(sat15(m_cyc))) begin
                n_errors++;
                $display("FAIL random_w4[%0d] got inv=%0d it=%0d cy=%0d exp inv=%0d it=%0d cy=%0d",
                         n, s_inv, s_iter, s_cyc, sat15(m_inv), sat15(m_iter), sat15(m_cyc));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_wait_cont();
        test_stall();
        test_saturation();
        test_quit();
        test_back_to_back();
        test_finish();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
